// File: rtl/xcfi_rvfi_trace_gen.sv
// xcfi_rvfi_trace_gen: RVFI trace producer sitting behind the writeback stage.
// Registers one rvfi_* packet per retirement; loads are held until their response arrives.
module xcfi_rvfi_trace_gen #(
    parameter int XLEN    = 32,
    parameter int ILEN    = 32,
    parameter int ORDER_W = 64
) (
    input  logic                 g_clk,
    input  logic                 g_reset,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [ILEN-1:0]      wb_insn,
    input  logic                 wb_trap,
    input  logic [XLEN-1:0]      wb_pc_rdata,
    input  logic [XLEN-1:0]      wb_pc_wdata,
    input  logic [4:0]           wb_rs1_addr,
    input  logic [4:0]           wb_rs2_addr,
    input  logic [4:0]           wb_rs3_addr,
    input  logic [XLEN-1:0]      wb_rs1_rdata,
    input  logic [XLEN-1:0]      wb_rs2_rdata,
    input  logic [XLEN-1:0]      wb_rs3_rdata,
    input  logic [4:0]           wb_rd_addr,
    input  logic [XLEN-1:0]      wb_rd_wdata,
    input  logic [XLEN-1:0]      wb_mem_addr,
    input  logic [XLEN/8-1:0]    wb_mem_rmask,
    input  logic [XLEN/8-1:0]    wb_mem_wmask,
    input  logic [XLEN-1:0]      wb_mem_wdata,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rsp_rdata,
    output logic                 rvfi_valid,
    output logic [ORDER_W-1:0]   rvfi_order,
    output logic [ILEN-1:0]      rvfi_insn,
    output logic                 rvfi_trap,
    output logic                 rvfi_halt,
    output logic                 rvfi_intr,
    output logic [XLEN-1:0]      rvfi_pc_rdata,
    output logic [XLEN-1:0]      rvfi_pc_wdata,
    output logic [4:0]           rvfi_rs1_addr,
    output logic [4:0]           rvfi_rs2_addr,
    output logic [4:0]           rvfi_rs3_addr,
    output logic [XLEN-1:0]      rvfi_rs1_rdata,
    output logic [XLEN-1:0]      rvfi_rs2_rdata,
    output logic [XLEN-1:0]      rvfi_rs3_rdata,
    output logic [4:0]           rvfi_rd_addr,
    output logic [XLEN-1:0]      rvfi_rd_wdata,
    output logic [XLEN-1:0]      rvfi_mem_addr,
    output logic [XLEN/8-1:0]    rvfi_mem_rmask,
    output logic [XLEN/8-1:0]    rvfi_mem_wmask,
    output logic [XLEN-1:0]      rvfi_mem_rdata,
    output logic [XLEN-1:0]      rvfi_mem_wdata
);
    localparam int MW = XLEN / 8;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    typedef struct packed {
        logic [ILEN-1:0] insn;
        logic            trap;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rs3_addr;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [XLEN-1:0] rs3_rdata;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
        logic [XLEN-1:0] mem_addr;
        logic [MW-1:0]   mem_rmask;
        logic [MW-1:0]   mem_wmask;
        logic [XLEN-1:0] mem_wdata;
        logic [XLEN-1:0] mem_rdata;
    } pkt_t;

    state_t             r_state;
    state_t             w_state_nxt;
    pkt_t               r_cap;
    pkt_t               r_out;
    pkt_t               w_in;
    pkt_t               w_src;
    pkt_t               w_pkt;
    logic               w_emit;
    logic               w_cap;
    logic               r_valid;
    logic               r_intr;
    logic               r_pend;
    logic [XLEN-1:0]    r_pend_pc;
    logic [ORDER_W-1:0] r_cnt;
    logic [ORDER_W-1:0] r_order;

    assign w_in = {wb_insn, wb_trap, wb_pc_rdata, wb_pc_wdata,
                   wb_rs1_addr, wb_rs2_addr, wb_rs3_addr,
                   wb_rs1_rdata, wb_rs2_rdata, wb_rs3_rdata,
                   wb_rd_addr, wb_rd_wdata, wb_mem_addr,
                   wb_mem_rmask, wb_mem_wmask, wb_mem_wdata,
                   {XLEN{1'b0}}};

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_cap       = 1'b0;
        wb_ready    = 1'b0;
        w_src       = w_in;
        unique case (r_state)
            IDLE: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    if (wb_mem_rmask == '0 || wb_trap) begin
                        w_emit = 1'b1;
                    end else begin
                        w_cap       = 1'b1;
                        w_state_nxt = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                w_src           = r_cap;
                w_src.rd_wdata  = mem_rsp_rdata;
                w_src.mem_rdata = mem_rsp_rdata;
                if (mem_rsp_valid) begin
                    w_emit      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // x0 never holds a value, and a trapped insn has no architectural effect
        w_pkt = w_src;
        if (w_pkt.rd_addr == 5'd0) begin
            w_pkt.rd_wdata = '0;
        end
        if (w_pkt.trap) begin
            w_pkt.rd_addr   = '0;
            w_pkt.rd_wdata  = '0;
            w_pkt.mem_rmask = '0;
            w_pkt.mem_wmask = '0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state   <= IDLE;
            r_cap     <= '0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_intr    <= 1'b0;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
            r_cnt     <= '0;
            r_order   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_emit;
            if (w_cap) begin
                r_cap <= w_in;
            end
            if (w_emit) begin
                r_out     <= w_pkt;
                r_order   <= r_cnt;
                r_cnt     <= r_cnt + 1'b1;
                r_intr    <= r_pend && (w_pkt.pc_rdata == r_pend_pc);
                r_pend    <= w_pkt.trap;
                r_pend_pc <= w_pkt.pc_wdata;
            end
        end
    end

    assign rvfi_valid     = r_valid;
    assign rvfi_order     = r_order;
    assign rvfi_insn      = r_out.insn;
    assign rvfi_trap      = r_out.trap;
    assign rvfi_halt      = 1'b0;
    assign rvfi_intr      = r_intr;
    assign rvfi_pc_rdata  = r_out.pc_rdata;
    assign rvfi_pc_wdata  = r_out.pc_wdata;
    assign rvfi_rs1_addr  = r_out.rs1_addr;
    assign rvfi_rs2_addr  = r_out.rs2_addr;
    assign rvfi_rs3_addr  = r_out.rs3_addr;
    assign rvfi_rs1_rdata = r_out.rs1_rdata;
    assign rvfi_rs2_rdata = r_out.rs2_rdata;
    assign rvfi_rs3_rdata = r_out.rs3_rdata;
    assign rvfi_rd_addr   = r_out.rd_addr;
    assign rvfi_rd_wdata  = r_out.rd_wdata;
    assign rvfi_mem_addr  = r_out.mem_addr;
    assign rvfi_mem_rmask = r_out.mem_rmask;
    assign rvfi_mem_wmask = r_out.mem_wmask;
    assign rvfi_mem_rdata = r_out.mem_rdata;
    assign rvfi_mem_wdata = r_out.mem_wdata;

endmodule
